// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the 65C02 core, the DMA requester and the memory decode/mux.
// The arbiter uses the slave modport; the surrounding system uses the master modport.
interface mem_bus_arbiter_if;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;

  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_en;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_ab, cpu_do, cpu_we,
    output cpu_di, cpu_rdy,
    input  dma_req, dma_addr, dma_wdata, dma_we,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_en,
    input  mem_rdata
  );

  modport master (
    output cpu_ab, cpu_do, cpu_we,
    input  cpu_di, cpu_rdy,
    output dma_req, dma_addr, dma_wdata, dma_we,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_en,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the synchronous-read memory port between the 65C02 and one DMA requester,
// stalling the CPU via RDY and bounding DMA bursts to MAX_BURST cycles.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  owner_t     own_q;
  logic [7:0] burst_q;
  logic       prev_cpu_q;
  logic [7:0] hold_q;
  logic       rvalid_q;
  logic       xfer;

  assign xfer = (own_q == OWN_DMA) && bus.dma_req;

  // A forced release needs no extra state: leaving OWN_DMA always costs one
  // full CPU-owned cycle before the next grant can take effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q      <= OWN_CPU;
      burst_q    <= 8'd0;
      stall_cnt  <= '0;
      hold_q     <= 8'd0;
      rvalid_q   <= 1'b0;
      prev_cpu_q <= 1'b0;
    end else begin
      case (own_q)
        OWN_CPU: begin
          burst_q <= 8'd0;
          if (bus.dma_req) own_q <= OWN_DMA;
        end
        OWN_DMA: begin
          if (bus.dma_req) burst_q <= burst_q + 8'd1;
          if (!bus.dma_req || (burst_q == BURST_LAST)) own_q <= OWN_CPU;
        end
        default: own_q <= OWN_CPU;
      endcase

      if ((own_q == OWN_DMA) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;

      rvalid_q   <= xfer && !bus.dma_we;
      prev_cpu_q <= (own_q == OWN_CPU);
      if (prev_cpu_q) hold_q <= bus.mem_rdata;
    end
  end

  assign bus.cpu_rdy    = (own_q == OWN_CPU);
  assign bus.dma_gnt    = (own_q == OWN_DMA);
  assign bus.dma_rvalid = rvalid_q;
  assign bus.dma_rdata  = bus.mem_rdata;

  // A CPU read issued just before a grant is caught in hold_q and stays put for the burst.
  assign bus.cpu_di = prev_cpu_q ? bus.mem_rdata : hold_q;

  always_comb begin
    bus.mem_addr  = bus.cpu_ab;
    bus.mem_wdata = bus.cpu_do;
    bus.mem_we    = bus.cpu_we;
    bus.mem_en    = 1'b1;
    if (own_q == OWN_DMA) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_we    = bus.dma_we & bus.dma_req;
      bus.mem_en    = bus.dma_req;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, hand-written corner sequences
// and a randomized phase compared against a rule-level reference model.
module tb_mem_bus_arbiter;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt1;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  mem_bus_arbiter_if bus1();

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt)
  );

  // Second instance exercises MAX_BURST=1 and a tiny saturating counter.
  mem_bus_arbiter #(.MAX_BURST(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .stall_cnt(stall_cnt1)
  );

  logic [7:0] ram [0:65535];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  bit         m_valid = 1'b0;
  bit         m_granted;
  int         m_run;
  int         m_stall;
  bit         m_rvalid;
  logic [7:0] m_rdata;
  logic [7:0] m_cpu_di;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: who owns this cycle follows from the request history and
  // the length of the current run of DMA transfers.
  task automatic model_step();
    if (m_valid) begin
      check_output("model cpu_rdy", 32'(bus.cpu_rdy), 32'(!m_granted));
      check_output("model dma_gnt", 32'(bus.dma_gnt), 32'(m_granted));
      check_output("model mem_en", 32'(bus.mem_en), 32'(m_granted ? bus.dma_req : 1'b1));
      check_output("model mem_we", 32'(bus.mem_we),
                   32'(m_granted ? (bus.dma_req & bus.dma_we) : bus.cpu_we));
      check_output("model mem_addr", 32'(bus.mem_addr), 32'(m_granted ? bus.dma_addr : bus.cpu_ab));
      check_output("model mem_wdata", 32'(bus.mem_wdata), 32'(m_granted ? bus.dma_wdata : bus.cpu_do));
      check_output("model dma_rvalid", 32'(bus.dma_rvalid), 32'(m_rvalid));
      if (m_rvalid) check_output("model dma_rdata", 32'(bus.dma_rdata), 32'(m_rdata));
      check_output("model cpu_di", 32'(bus.cpu_di), 32'(m_cpu_di));
      check_output("model stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end
    if (reset) begin
      m_valid   = 1'b1;
      m_granted = 1'b0;
      m_run     = 0;
      m_stall   = 0;
      m_rvalid  = 1'b0;
      m_cpu_di  = 8'h00;
    end else if (m_valid) begin
      if (m_granted && m_stall < 65535) m_stall++;
      m_rvalid = m_granted && bus.dma_req && !bus.dma_we;
      m_rdata  = ram[bus.dma_addr];
      if (!m_granted) begin
        m_cpu_di  = ram[bus.cpu_ab];
        m_granted = bus.dma_req;
        m_run     = 0;
      end else if (!bus.dma_req) begin
        m_granted = 1'b0;
      end else begin
        m_run++;
        if (m_run == MAX_BURST) m_granted = 1'b0;
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic req, input logic we,
                                input logic [15:0] addr, input logic [7:0] wdata,
                                input logic [15:0] ab, input logic cwe, input logic [7:0] cdo);
    @(negedge clk);
    reset         = rst;
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
    bus.cpu_ab    = ab;
    bus.cpu_we    = cwe;
    bus.cpu_do    = cdo;
    #1;
    model_step();
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_rdy;
    logic        exp_gnt;
    logic        exp_mem_we;
    logic [15:0] exp_mem_addr;
    logic        exp_rvalid;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [15:0] ab;
    bit          exp_g;

    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h0300] = 8'hC3;
    ram[16'hC000] = 8'hA9;
    bus1.dma_req   = 1'b0;
    bus1.dma_we    = 1'b0;
    bus1.dma_addr  = 16'h0000;
    bus1.dma_wdata = 8'h00;
    bus1.cpu_ab    = 16'h0000;
    bus1.cpu_we    = 1'b0;
    bus1.cpu_do    = 8'h00;
    bus1.mem_rdata = 8'h00;

    // Write lands on the grant cycle; the idle DMA cycle after it also stalls.
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 8'h00, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 8'h5A, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 8'h00, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 16'h0200, 8'h5A, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 8'h00, 16'd0};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'd1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 8'h00, 16'd2};
    vecs[5] = '{1'b1, 1'b0, 16'h0300, 8'h00, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 8'h00, 16'd2};
    vecs[6] = '{1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0300, 1'b0, 8'h00, 16'd2};
    vecs[7] = '{1'b0, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0300, 1'b1, 8'hC3, 16'd3};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 8'h00, 16'd4};

    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1000, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1000, 1'b0, 8'h00);
    check_output("reset cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    check_output("reset dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_output("reset dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check_output("reset cpu_di", 32'(bus.cpu_di), 32'd0);
    check_output("reset stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < 20; i++) begin
      ab = 16'($urandom_range(0, 16'h7FFF));
      apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, ab, 1'b0, 8'h00);
      check_output("idle cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
      check_output("idle mem_addr", 32'(bus.mem_addr), 32'(ab));
    end
    check_output("idle stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b0, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, 16'h1000, 1'b0, 8'h00);
      check_output($sformatf("vec%0d cpu_rdy", i), 32'(bus.cpu_rdy), 32'(vecs[i].exp_rdy));
      check_output($sformatf("vec%0d dma_gnt", i), 32'(bus.dma_gnt), 32'(vecs[i].exp_gnt));
      check_output($sformatf("vec%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_mem_we));
      check_output($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_mem_addr));
      check_output($sformatf("vec%0d dma_rvalid", i), 32'(bus.dma_rvalid), 32'(vecs[i].exp_rvalid));
      if (vecs[i].exp_rvalid)
        check_output($sformatf("vec%0d dma_rdata", i), 32'(bus.dma_rdata), 32'(vecs[i].exp_rdata));
      check_output($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
    end

    // Continuous requests: 8 granted cycles then one CPU cycle; MAX_BURST=1 alternates.
    bus1.dma_req = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1000, 1'b0, 8'h00);
    for (int c = 0; c < 29; c++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'(16'h0400 + c), 8'h00, 16'h1000, 1'b0, 8'h00);
      exp_g = (c == 0) ? 1'b0 : (((c - 1) % 9) != 8);
      check_output($sformatf("burst c%0d dma_gnt", c), 32'(bus.dma_gnt), 32'(exp_g));
      exp_g = (c == 0) ? 1'b0 : (((c - 1) % 2) == 0);
      check_output($sformatf("burst1 c%0d dma_gnt", c), 32'(bus1.dma_gnt), 32'(exp_g));
    end
    check_output("burst stall_cnt", 32'(stall_cnt), 32'd24);
    check_output("burst1 stall_cnt saturated", 32'(stall_cnt1), 32'd7);
    bus1.dma_req = 1'b0;

    // CPU read of 0xC000 as the request rises must stay on cpu_di through the burst.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'hC000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0300, 8'h00, 16'hC000, 1'b0, 8'h00);
    for (int g = 1; g <= 5; g++) begin
      apply_stimulus(1'b0, (g <= 4), 1'b0, 16'h0300, 8'h00, 16'hC000, 1'b0, 8'h00);
      check_output($sformatf("hold g%0d cpu_rdy", g), 32'(bus.cpu_rdy), 32'd0);
      check_output($sformatf("hold g%0d cpu_di", g), 32'(bus.cpu_di), 32'hA9);
    end

    // Reset in the third cycle of a read burst.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0300, 8'h00, 16'h1000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0300, 8'h00, 16'h1000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0300, 8'h00, 16'h1000, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0300, 8'h00, 16'h1000, 1'b0, 8'h00);
    check_output("midburst pre-reset dma_gnt", 32'(bus.dma_gnt), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1000, 1'b0, 8'h00);
    check_output("midburst cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    check_output("midburst dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_output("midburst dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check_output("midburst stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 16'h7FFF)),
                     8'($urandom),
                     16'($urandom),
                     ($urandom_range(0, 3) == 0),
                     8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
